iob_regfile_wr_arb: RTL and testbench
=====================================

# iob_regfile_wr_arb

Write-port arbiter that shares the single write port of an `iob_regfile_w_r` instance between `N_REQ` independent requesters. Each requester offers an address/data pair with a valid/ready handshake. The arbiter grants at most one requester per cycle and drives the register file write port from an output register. It sits directly in front of the register file, and both blocks share `clk_i`, `arst_n_i` and `en_i`.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `ADDR_W`, 4, register file address width (≥1)
- `DATA_W`, 32, register file data width (≥1)
- `PTR_W`, `$clog2(N_REQ)`, round-robin pointer width (derived; do not override)

Ports:
- `clk_i`  in  1  clock; all state on rising edge
- `arst_n_i`  in  1  asynchronous active-low reset
- `en_i`  in  1  global enable, shared with the register file
- `req_valid_i`  in  `N_REQ`  per-requester write request
- `req_addr_i`  in  `N_REQ*ADDR_W`  packed addresses; requester k at bits `[k*ADDR_W +: ADDR_W]`
- `req_data_i`  in  `N_REQ*DATA_W`  packed data; requester k at bits `[k*DATA_W +: DATA_W]`
- `req_ready_o`  out  `N_REQ`  one-hot or zero grant (combinational)
- `we_o`  out  1  register file write enable (registered)
- `waddr_o`  out  `ADDR_W`  register file write address (registered)
- `wdata_o`  out  `DATA_W`  register file write data (registered)
- `grant_o`  out  `N_REQ`  one-hot source of the current `we_o` pulse (registered)

## Operation
- **Handshake:** a transfer occurs for requester k when `req_valid_i[k] & req_ready_o[k]` are high in the same cycle.
  - Once `req_valid_i[k]` is raised, it must stay high with stable addr/data until accepted.
- **Grant:** `req_ready_o` is combinational from `req_valid_i`, `en_i` and the pointer.
  - At most one bit is high.
  - All bits are 0 when `en_i=0` or no request is pending.
- **Round-robin:** search starts at pointer `ptr`. The granted index is the first valid index in the order `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`.
- **Pointer update:**
  - After a grant to k: `ptr ← (k==N_REQ-1) ? 0 : k+1`. Wrap is at `N_REQ-1`, not at `2**PTR_W-1`.
  - No grant: `ptr` holds.
- **Write output:**
  - On a transfer: `we_o←1`, `waddr_o←req_addr[k]`, `wdata_o←req_data[k]`, `grant_o←onehot(k)`.
  - No transfer with `en_i=1`: `we_o←0`, `grant_o←0`; `waddr_o` and `wdata_o` hold.
- **`en_i=0`:** no grants, `we_o←0`, `grant_o←0`; `ptr`, `waddr_o` and `wdata_o` hold.
- **Same address from several requesters:** these are serialised in arbitration order. The last write wins in the register file. No merging.
- **Reset (asynchronous assert, any time):**
  - `ptr=0`, `we_o=0`, `waddr_o=0`, `wdata_o=0`, `grant_o=0`.
  - `req_ready_o=0` while `arst_n_i=0`.
  - A transfer in flight at reset assertion is lost.
  - Deassertion takes effect synchronously.

## Timing
- **Acceptance to write:** 1 cycle. A transfer at edge n produces `we_o=1` during cycle n+1. The register file captures it at edge n+1 and makes it readable from cycle n+2.
- **Throughput:** one write per cycle sustained. No bubble between back-to-back grants, including to the same requester.
- **Fairness:** with all N_REQ requesters continuously valid, each receives exactly one grant every N_REQ cycles.
- **Combinational paths:** `req_valid_i`/`en_i` → `req_ready_o` only. No path to `we_o`/`waddr_o`/`wdata_o`.

## Configuration
- Macro: `IOB_REGFILE_WR_ARB_RR_EN`.
- **Defined:** round-robin arbitration as above.
- **Undefined:**
  - Fixed priority: the lowest valid index always wins.
  - `ptr` is removed and is not synthesised.
  - Starvation of high indices is permitted.
  - All other behaviour and timing are unchanged.

## Test plan
- **Reset:** hold `arst_n_i=0` with all valid high → `req_ready_o=0`, `we_o=0`, `waddr_o=0`, `wdata_o=0`, `grant_o=0`. After release, the first grant goes to requester 0.
- **Single requester:** requester 2 with addr 5, data 0xDEADBEEF, `en_i=1` → `req_ready_o=4'b0100` that cycle. Next cycle `we_o=1`, `waddr_o=5`, `wdata_o=0xDEADBEEF`, `grant_o=4'b0100`. The register file reads 0xDEADBEEF at addr 5 one cycle later.
- **All four valid, continuous, RR defined:** grant order 0,1,2,3,0,… with `we_o` high every cycle. With the macro undefined, requester 0 is granted every cycle.
- **Wrap and skip:** valid = {1,3} with `ptr=2` → grant 3 and `ptr` wraps to 0; next grant 1. Use `N_REQ=3` to check that the wrap occurs at index 2.
- **`en_i` low mid-stream:** drop `en_i` for 2 cycles while all requests are valid → no ready, `we_o=0`, `ptr` unchanged. After restore, arbitration resumes from the held `ptr` and no write is duplicated.
- **Reset mid-operation:** assert `arst_n_i` in the cycle after a transfer → `we_o` clears immediately and the register file contents for that address are unchanged.

Source files
------------

// File: rtl/iob_regfile_wr_arb.sv
// Write-port arbiter in front of iob_regfile_w_r: N_REQ valid/ready requesters share one registered write port.
// Define IOB_REGFILE_WR_ARB_RR_EN for round-robin; otherwise lowest index wins (fixed priority).
module iob_regfile_wr_arb #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32,
   parameter int PTR_W  = $clog2(N_REQ)
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic                      en_i,
   input  logic [N_REQ-1:0]          req_valid_i,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]   req_data_i,
   output logic [N_REQ-1:0]          req_ready_o,
   output logic                      we_o,
   output logic [ADDR_W-1:0]         waddr_o,
   output logic [DATA_W-1:0]         wdata_o,
   output logic [N_REQ-1:0]          grant_o
);

   logic [PTR_W-1:0]  base;
   logic [PTR_W-1:0]  cand_idx [N_REQ];
   logic [N_REQ-1:0]  search_vec;
   logic [ADDR_W-1:0] addr_arr [N_REQ];
   logic [DATA_W-1:0] data_arr [N_REQ];
   logic              gnt_found;
   logic [PTR_W-1:0]  gnt_idx;
   logic              xfer;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [N_REQ-1:0]  grant_q, grant_d;

   // Search slot gi examines requester (base + gi) mod N_REQ, so slot 0 has top priority.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [PTR_W:0] sum;
         assign sum = {1'b0, base} + (PTR_W+1)'(gi);
         assign cand_idx[gi]   = (sum >= (PTR_W+1)'(N_REQ)) ?
                                 PTR_W'(sum - (PTR_W+1)'(N_REQ)) : sum[PTR_W-1:0];
         assign search_vec[gi] = req_valid_i[cand_idx[gi]];
         assign addr_arr[gi]   = req_addr_i[gi*ADDR_W +: ADDR_W];
         assign data_arr[gi]   = req_data_i[gi*DATA_W +: DATA_W];
      end
   endgenerate

`ifdef IOB_REGFILE_WR_ARB_RR_EN
   logic [PTR_W-1:0] ptr_q, ptr_d;

   assign base = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign base = '0;
`endif

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!gnt_found && search_vec[i]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx[i];
         end
      end
   end

   // Ready is also forced low while reset is asserted, independent of the clock.
   assign req_ready_o = (gnt_found && en_i && arst_n_i) ? (N_REQ'(1) << gnt_idx) : '0;
   assign xfer        = |req_ready_o;

   always_comb begin
      we_d    = xfer;
      grant_d = req_ready_o;
      waddr_d = xfer ? addr_arr[gnt_idx] : waddr_q;
      wdata_d = xfer ? data_arr[gnt_idx] : wdata_q;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         grant_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         grant_q <= grant_d;
      end
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign grant_o = grant_q;

endmodule

// File: tb/tb_iob_regfile_wr_arb.sv
// Bench for iob_regfile_wr_arb: a 4-requester and a 3-requester instance checked against a
// transaction-level model of pending requests, arbitration order and the registered write port.
module tb_iob_regfile_wr_arb;

`ifdef IOB_REGFILE_WR_ARB_RR_EN
   localparam bit RR_M = 1'b1;
`else
   localparam bit RR_M = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic en = 1'b0;

   logic [3:0]   v0 = '0;
   logic [15:0]  a0 = '0;
   logic [127:0] d0 = '0;
   logic [3:0]   ready0, grant0;
   logic         we0;
   logic [3:0]   waddr0;
   logic [31:0]  wdata0;

   logic [2:0]   v1 = '0;
   logic [11:0]  a1 = '0;
   logic [95:0]  d1 = '0;
   logic [2:0]   ready1, grant1;
   logic         we1;
   logic [3:0]   waddr1;
   logic [31:0]  wdata1;

   int checks = 0;
   int errors = 0;

   // Model state: per-instance pending requests, pointer and expected write port.
   bit          pend [2][4];
   logic [3:0]  ad   [2][4];
   logic [31:0] da   [2][4];
   int          ptr_m [2];
   int          kk    [2];
   logic        exp_we    [2];
   logic [3:0]  exp_waddr [2];
   logic [31:0] exp_wdata [2];
   logic [3:0]  exp_grant [2];

   always #5 clk = ~clk;

   iob_regfile_wr_arb #(.N_REQ(4), .ADDR_W(4), .DATA_W(32)) dut0 (
      .clk_i(clk), .arst_n_i(arst_n), .en_i(en),
      .req_valid_i(v0), .req_addr_i(a0), .req_data_i(d0),
      .req_ready_o(ready0), .we_o(we0), .waddr_o(waddr0), .wdata_o(wdata0), .grant_o(grant0)
   );

   iob_regfile_wr_arb #(.N_REQ(3), .ADDR_W(4), .DATA_W(32)) dut1 (
      .clk_i(clk), .arst_n_i(arst_n), .en_i(en),
      .req_valid_i(v1), .req_addr_i(a1), .req_data_i(d1),
      .req_ready_o(ready1), .we_o(we1), .waddr_o(waddr1), .wdata_o(wdata1), .grant_o(grant1)
   );

   function automatic int nreq(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   // First pending requester in arbitration order, or -1 when nothing may be granted.
   function automatic int pick(input int d);
      int n, k;
      n = nreq(d);
      if (!en || !arst_n) return -1;
      for (int off = 0; off < n; off++) begin
         k = RR_M ? (ptr_m[d] + off) % n : off;
         if (pend[d][k]) return k;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 4; k++) begin
         v0[k] = pend[0][k];
         a0[k*4 +: 4] = ad[0][k];
         d0[k*32 +: 32] = da[0][k];
      end
      for (int k = 0; k < 3; k++) begin
         v1[k] = pend[1][k];
         a1[k*4 +: 4] = ad[1][k];
         d1[k*32 +: 32] = da[1][k];
      end
   endtask

   task automatic set_req(input int d, input int k, input logic [3:0] a, input logic [31:0] dat);
      pend[d][k] = 1'b1;
      ad[d][k]   = a;
      da[d][k]   = dat;
   endtask

   task automatic new_reqs(input int prob);
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < nreq(d); k++)
            if (!pend[d][k] && $urandom_range(99) < prob)
               set_req(d, k, 4'($urandom_range(15)), $urandom);
   endtask

   task automatic check_ready();
      kk[0] = pick(0);
      kk[1] = pick(1);
      chk("ready0", 128'(ready0), (kk[0] < 0) ? 128'(0) : (128'(1) << kk[0]));
      chk("ready1", 128'(ready1), (kk[1] < 0) ? 128'(0) : (128'(1) << kk[1]));
   endtask

   task automatic check_outs();
      chk("we0",    128'(we0),    128'(exp_we[0]));
      chk("waddr0", 128'(waddr0), 128'(exp_waddr[0]));
      chk("wdata0", 128'(wdata0), 128'(exp_wdata[0]));
      chk("grant0", 128'(grant0), 128'(exp_grant[0]));
      chk("we1",    128'(we1),    128'(exp_we[1]));
      chk("waddr1", 128'(waddr1), 128'(exp_waddr[1]));
      chk("wdata1", 128'(wdata1), 128'(exp_wdata[1]));
      chk("grant1", 128'(grant1), 128'(exp_grant[1]));
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         ptr_m[d] = 0;
         exp_we[d] = 1'b0;
         exp_waddr[d] = '0;
         exp_wdata[d] = '0;
         exp_grant[d] = '0;
      end
   endtask

   // One clock: drive at the falling edge, check ready, advance, check registered outputs.
   task automatic cycle();
      int k;
      drive();
      #1;
      check_ready();
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         k = kk[d];
         if (k >= 0) begin
            exp_we[d]    = 1'b1;
            exp_waddr[d] = ad[d][k];
            exp_wdata[d] = da[d][k];
            exp_grant[d] = 4'(1 << k);
            pend[d][k]   = 1'b0;
            if (RR_M) ptr_m[d] = (k == nreq(d) - 1) ? 0 : k + 1;
         end else begin
            exp_we[d]    = 1'b0;
            exp_grant[d] = '0;
         end
      end
      @(negedge clk);
      check_outs();
      $display("t=%0t en=%0b v0=%b ready0=%b we0=%0b waddr0=%0h wdata0=%08h | v1=%b ready1=%b we1=%0b",
               $time, en, v0, ready0, we0, waddr0, wdata0, v1, ready1, we1);
   endtask

   initial begin
      model_reset();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 4; k++) begin
            pend[d][k] = 1'b0;
            ad[d][k] = '0;
            da[d][k] = '0;
         end

      // Reset held with every requester valid.
      en = 1'b1;
      new_reqs(100);
      drive();
      @(posedge clk);
      @(negedge clk);
      check_ready();
      check_outs();

      // Release; first grants come from requester 0.
      arst_n = 1'b1;
      for (int i = 0; i < 6; i++) cycle();

      // Single requester 2 with a known transaction.
      set_req(0, 2, 4'd5, 32'hDEADBEEF);
      set_req(1, 2, 4'd5, 32'hDEADBEEF);
      cycle();
      cycle();

      // All valid continuously, refilled every cycle.
      for (int i = 0; i < 12; i++) begin
         new_reqs(100);
         cycle();
      end

      // Enable dropped for two cycles mid-stream.
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         new_reqs(100);
         cycle();
      end
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         new_reqs(100);
         cycle();
      end

      // Drain, then wrap-and-skip: move pointer to 2, then offer requesters past and before it.
      for (int i = 0; i < 5; i++) cycle();
      set_req(0, 1, 4'h1, 32'h1111_0001);
      set_req(1, 1, 4'h1, 32'h2222_0001);
      cycle();
      set_req(0, 1, 4'h6, 32'h1111_0002);
      set_req(0, 3, 4'h7, 32'h1111_0003);
      set_req(1, 0, 4'h8, 32'h2222_0000);
      set_req(1, 1, 4'h9, 32'h2222_0002);
      for (int i = 0; i < 3; i++) cycle();

      // Several requesters targeting the same address.
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < nreq(d); k++) set_req(d, k, 4'hA, 32'hA000_0000 + 32'(k));
      for (int i = 0; i < 5; i++) cycle();

      // Randomised traffic with occasional enable drops.
      for (int i = 0; i < 300; i++) begin
         new_reqs(50);
         en = ($urandom_range(9) != 0);
         cycle();
      end
      en = 1'b1;

      // Reset asserted in the cycle after a transfer.
      new_reqs(100);
      cycle();
      #2;
      arst_n = 1'b0;
      model_reset();
      #1;
      check_outs();
      check_ready();
      @(negedge clk);
      check_outs();
      arst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         new_reqs(70);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
